// File: rtl/risc_pkg.sv
// Shared constants for the 8-bit RISC CPU: opcode values, sequencer phases, default widths.
// Reused by the controller, its counters and the ALU datapath.
package risc_pkg;

   localparam int DEF_ADDR_W = 5;
   localparam int DEF_OPC_W  = 3;

   localparam logic [DEF_OPC_W-1:0] HLT = 3'd0;
   localparam logic [DEF_OPC_W-1:0] SKZ = 3'd1;
   localparam logic [DEF_OPC_W-1:0] ADD = 3'd2;
   localparam logic [DEF_OPC_W-1:0] AND = 3'd3;
   localparam logic [DEF_OPC_W-1:0] XOR = 3'd4;
   localparam logic [DEF_OPC_W-1:0] LDA = 3'd5;
   localparam logic [DEF_OPC_W-1:0] STO = 3'd6;
   localparam logic [DEF_OPC_W-1:0] JMP = 3'd7;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } phase_t;

   function automatic logic is_aluop(input logic [DEF_OPC_W-1:0] opc);
      return (opc == ADD) || (opc == AND) || (opc == XOR) || (opc == LDA);
   endfunction

endpackage

// File: rtl/risc_controller_if.sv
// Controller <-> memory/datapath signal bundle; master is the controller side.
// Purely combinational wiring, no flow control.
interface risc_controller_if;
   import risc_pkg::*;

   logic [DEF_ADDR_W+DEF_OPC_W-1:0] mem_rdata;
   logic                            acc_zero;
   logic [DEF_ADDR_W-1:0]           mem_addr;
   logic                            mem_rd;
   logic                            mem_wr;
   logic                            ld_ac;
   logic [DEF_OPC_W-1:0]            opcode;
   logic                            halt;
   logic [DEF_ADDR_W-1:0]           pc_out;

   modport master (
      input  mem_rdata, acc_zero,
      output mem_addr, mem_rd, mem_wr, ld_ac, opcode, halt, pc_out
   );

   modport slave (
      output mem_rdata, acc_zero,
      input  mem_addr, mem_rd, mem_wr, ld_ac, opcode, halt, pc_out
   );

endinterface

// File: rtl/risc_counter.sv
// Loadable wrapping up-counter with enable; load takes priority over increment.
// Single-cycle update, no backpressure.
module risc_counter #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en_i,
   input  logic         ld_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (ld_i) begin
         q_d = d_i;
      end else if (en_i) begin
         q_d = q_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q <= '0;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o = q_q;

endmodule

// File: rtl/risc_controller.sv
// Fetch/execute sequencer: owns PC, IR and phase; decodes memory strobes and ALU controls.
// Latency: 8 clocks per instruction, outputs combinational from phase/IR; no backpressure.
module risc_controller
   import risc_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int OPC_W  = DEF_OPC_W
) (
   input  logic                clk,
   input  logic                rst_n,
   risc_controller_if.master   bus
);

   localparam int INST_W = ADDR_W + OPC_W;

   logic [2:0]        phase_cnt;
   phase_t            phase;
   logic              phase_en;
   logic [ADDR_W-1:0] pc;
   logic              pc_en;
   logic              pc_ld;
   logic [INST_W-1:0] ir_q, ir_d;
   logic              halt_q, halt_d;
   logic [OPC_W-1:0]  opc;
   logic [ADDR_W-1:0] operand;
   logic              aluop;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic              ld_ac;

   assign phase   = phase_t'(phase_cnt);
   assign opc     = ir_q[INST_W-1:ADDR_W];
   assign operand = ir_q[ADDR_W-1:0];
   assign aluop   = is_aluop(opc);

   risc_counter #(.W(3)) u_phase (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (phase_en),
      .ld_i  (1'b0),
      .d_i   (3'd0),
      .q_o   (phase_cnt)
   );

   risc_counter #(.W(ADDR_W)) u_pc (
      .clk   (clk),
      .rst_n (rst_n),
      .en_i  (pc_en),
      .ld_i  (pc_ld),
      .d_i   (operand),
      .q_o   (pc)
   );

   always_comb begin
      ir_d     = ir_q;
      halt_d   = halt_q;
      phase_en = !halt_q;
      pc_en    = 1'b0;
      pc_ld    = 1'b0;
      mem_addr = pc;
      mem_rd   = 1'b0;
      mem_wr   = 1'b0;
      ld_ac    = 1'b0;
      case (phase)
         INST_ADDR: ;
         INST_FETCH: mem_rd = 1'b1;
         INST_LOAD, IDLE: begin
            mem_rd = 1'b1;
            ir_d   = bus.mem_rdata;
         end
         OP_ADDR: begin
            mem_addr = operand;
            // Halt parks the sequencer here; PC still steps once on entry.
            if (!halt_q) begin
               pc_en = 1'b1;
               if (opc == HLT) begin
                  halt_d   = 1'b1;
                  phase_en = 1'b0;
               end
            end
         end
         OP_FETCH: begin
            mem_addr = operand;
            mem_rd   = aluop;
         end
         ALU_OP: begin
            mem_addr = operand;
            mem_rd   = aluop;
            pc_en    = (opc == SKZ) && bus.acc_zero;
         end
         STORE: begin
            mem_addr = operand;
            mem_rd   = aluop;
            ld_ac    = aluop;
            mem_wr   = (opc == STO);
            pc_ld    = (opc == JMP);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_q   <= '0;
         halt_q <= 1'b0;
      end else begin
         ir_q   <= ir_d;
         halt_q <= halt_d;
      end
   end

   assign bus.mem_addr = mem_addr;
   assign bus.mem_rd   = mem_rd;
   assign bus.mem_wr   = mem_wr;
   assign bus.ld_ac    = ld_ac;
   assign bus.opcode   = opc;
   assign bus.halt     = halt_q;
   assign bus.pc_out   = pc;

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench: instruction-level model pushes per-cycle expectations, negedge monitor compares.
module tb_risc_controller;

   typedef struct packed {
      logic [4:0] addr;
      logic       rd;
      logic       wr;
      logic       ld;
      logic [2:0] opc;
      logic       halt;
      logic [4:0] pc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       acc_zero_r;
   logic [7:0] mem [32];

   exp_t sb_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   wr_seen = 0;
   int   wr_exp  = 0;

   logic [4:0] m_pc;
   logic [7:0] m_ir;

   risc_controller_if bus ();

   assign bus.mem_rdata = mem[bus.mem_addr];
   assign bus.acc_zero  = acc_zero_r;

   risc_controller dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      exp_t e, a;
      if (bus.mem_wr) wr_seen++;
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         a = '{addr: bus.mem_addr, rd: bus.mem_rd, wr: bus.mem_wr, ld: bus.ld_ac,
               opc: bus.opcode, halt: bus.halt, pc: bus.pc_out};
         n_vec++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL cycle@%0t got addr=%0d rd=%b wr=%b ld=%b opc=%0d halt=%b pc=%0d want addr=%0d rd=%b wr=%b ld=%b opc=%0d halt=%b pc=%0d",
                     $time, a.addr, a.rd, a.wr, a.ld, a.opc, a.halt, a.pc,
                     e.addr, e.rd, e.wr, e.ld, e.opc, e.halt, e.pc);
         end
      end
   end

   task automatic push(input exp_t e);
      sb_q.push_back(e);
      if (e.wr) wr_exp++;
   endtask

   task automatic do_reset(input int n);
      exp_t e;
      rst_n = 1'b0;
      m_pc  = '0;
      m_ir  = '0;
      e = '0;
      for (int i = 0; i < n; i++) begin
         acc_zero_r = 1'($urandom_range(0, 1));
         push(e);
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
   endtask

   // One instruction: word at PC, 8 phases of expected bus activity.
   // az_mode: 0/1 force acc_zero, 2 random. abort_at: phase at which reset hits (-1 none).
   task automatic run_instr(input int az_mode, input int abort_at, output bit halted);
      logic [7:0] w;
      logic [7:0] cur;
      logic [2:0] op;
      logic       alu;
      logic       az;
      exp_t       e;
      halted = 1'b0;
      w = mem[m_pc];
      for (int p = 0; p < 8; p++) begin
         if (p == abort_at) begin
            do_reset(2);
            return;
         end
         az = (az_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(az_mode);
         acc_zero_r = az;
         cur = (p < 3) ? m_ir : w;
         op  = cur[7:5];
         alu = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
         e.addr = (p < 4) ? m_pc : cur[4:0];
         e.rd   = (p >= 1 && p <= 3) || (p >= 5 && alu);
         e.wr   = (p == 7) && (op == 3'd6);
         e.ld   = (p == 7) && alu;
         e.opc  = op;
         e.halt = 1'b0;
         e.pc   = m_pc;
         push(e);
         @(posedge clk); #1;
         if (p == 2) m_ir = w;
         if (p == 4) m_pc = m_pc + 5'd1;
         if (p == 4 && op == 3'd0) begin
            for (int k = 0; k < 20; k++) begin
               acc_zero_r = 1'($urandom_range(0, 1));
               e = '0;
               e.addr = w[4:0];
               e.halt = 1'b1;
               e.pc   = m_pc;
               push(e);
               @(posedge clk); #1;
            end
            halted = 1'b1;
            return;
         end
         if (p == 6 && op == 3'd1 && az) m_pc = m_pc + 5'd1;
         if (p == 7 && op == 3'd7) m_pc = w[4:0];
      end
   endtask

   task automatic fill_mem();
      logic [7:0] w;
      for (int i = 0; i < 32; i++) begin
         w = 8'($urandom);
         if (w[7:5] == 3'd0 && $urandom_range(0, 3) != 0) w[7:5] = 3'd2;
         mem[i] = w;
      end
   endtask

   initial begin
      bit h;
      rst_n = 1'b0;
      acc_zero_r = 1'b0;
      fill_mem();
      for (int i = 0; i < 32; i++) if (mem[i][7:5] == 3'd0) mem[i] = 8'h41;
      @(posedge clk); #1;
      do_reset(3);

      mem[0] = 8'hA5; mem[5] = 8'h3C;
      do_reset(2);
      run_instr(2, -1, h); run_instr(2, -1, h);

      mem[0] = 8'hDF;
      do_reset(2);
      run_instr(2, -1, h); run_instr(2, -1, h);

      mem[0] = 8'hE3; mem[3] = 8'h45;
      do_reset(2);
      run_instr(2, -1, h); run_instr(2, -1, h);

      mem[0] = 8'h20;
      do_reset(2);
      run_instr(1, -1, h); run_instr(2, -1, h);
      do_reset(2);
      run_instr(0, -1, h); run_instr(2, -1, h);

      mem[0] = 8'h00;
      do_reset(2);
      run_instr(2, -1, h);
      mem[0] = 8'hA5;
      do_reset(2);
      run_instr(2, -1, h);

      mem[0] = 8'hFF; mem[31] = 8'h40;
      do_reset(2);
      run_instr(2, -1, h); run_instr(2, -1, h); run_instr(2, -1, h);

      mem[0] = 8'hDF;
      do_reset(2);
      run_instr(2, 6, h);
      mem[0] = 8'h45;
      do_reset(1);
      run_instr(2, -1, h);

      for (int r = 0; r < 8; r++) begin
         fill_mem();
         do_reset(2);
         for (int k = 0; k < 12; k++) begin
            run_instr(2, (($urandom_range(0, 29) == 0) ? int'($urandom_range(1, 7)) : -1), h);
            if (h) break;
         end
      end

      do_reset(1);
      @(negedge clk); #1;
      n_vec++;
      if (wr_seen != wr_exp) begin
         n_fail++;
         $display("FAIL wr_count got %0d want %0d", wr_seen, wr_exp);
      end
      n_vec++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain got %0d left want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
